// File: rtl/dsp_mac_sequencer.sv
// Operand-FIFO sequencer that issues dot-product jobs to a DSP slice as unbroken MAC chains.
// Optional DRAIN watchdog enabled by defining SEQ_WDOG_EN.
module dsp_mac_sequencer #(
  parameter int N         = 9,
  parameter int M         = 9,
  parameter int OPQ_DEPTH = 16,
  parameter int LEN_W     = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_mode,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [1:0]       cmd_shift,
  input  logic [N+M-1:0]   cmd_bias,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [N-1:0]     op_a,
  input  logic [M-1:0]     op_b,
  output logic             dsp_start,
  output logic [1:0]       dsp_mode,
  output logic [N-1:0]     dsp_aa,
  output logic [M-1:0]     dsp_bb,
  output logic [N+M-1:0]   dsp_cc,
  output logic             dsp_mac,
  output logic [1:0]       dsp_shift,
  input  logic [N+M-1:0]   dsp_out,
  input  logic             dsp_valid,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [N+M-1:0]   res_data,
  output logic             err
);

  localparam int PW = (OPQ_DEPTH > 1) ? $clog2(OPQ_DEPTH) : 1;
  localparam int W  = N + M;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  logic [2:0]          state, state_nxt;
  logic signed [N-1:0] fifo_a [OPQ_DEPTH];
  logic signed [M-1:0] fifo_b [OPQ_DEPTH];
  logic [PW-1:0]       wptr, rptr;
  logic [LEN_W-1:0]    fcnt;
  logic                full, push, pop;

  logic                cmd_fire, cmd_illegal;
  logic [1:0]          job_mode, job_shift;
  logic [LEN_W-1:0]    job_len, icnt, vcnt;
  logic signed [W-1:0] job_bias;
  logic                job_active, last_issue, final_vld, wdog_exp;

  logic signed [N-1:0] aa_s, aa_p0, aa_p1, aa_p2;
  logic signed [M-1:0] bb_s, bb_p0, bb_p1, bb_p2;
  logic signed [W-1:0] cc_s, cc_p0, cc_p1, cc_p2;
  logic                vld_s, vld_p0, vld_p1, vld_p2;

  assign full        = (fcnt == LEN_W'(OPQ_DEPTH));
  assign push        = op_valid && !full;
  assign pop         = (state == S_ISSUE);
  assign cmd_fire    = cmd_valid && cmd_ready;
  assign cmd_illegal = (cmd_mode == 2'd3) || (cmd_len == '0) || (cmd_len > LEN_W'(OPQ_DEPTH));
  assign job_active  = (state == S_ISSUE) || (state == S_DRAIN);
  assign last_issue  = (icnt == job_len - LEN_W'(1));
  assign final_vld   = job_active && dsp_valid && (vcnt == job_len - LEN_W'(1));

  assign cmd_ready = (state == S_IDLE);
  assign op_ready  = !full;
  assign dsp_start = (state == S_ISSUE);
  assign dsp_mode  = job_active ? job_mode  : 2'd0;
  assign dsp_shift = job_active ? job_shift : 2'd0;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_a[wptr] <= op_a;
      fifo_b[wptr] <= op_b;
    end
  end

  always_ff @(posedge clk) begin
    if (cmd_fire && !cmd_illegal) job_bias <= cmd_bias;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      fcnt <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      case ({push, pop})
        2'b10:   fcnt <= fcnt + LEN_W'(1);
        2'b01:   fcnt <= fcnt - LEN_W'(1);
        default: fcnt <= fcnt;
      endcase
    end
  end

`ifdef SEQ_WDOG_EN
  logic [3:0] wdog;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 wdog <= '0;
    else if (state != S_DRAIN)  wdog <= '0;
    else                        wdog <= wdog + 4'd1;
  end

  // Expires on the 8th DRAIN cycle after the final issue beat.
  assign wdog_exp = (state == S_DRAIN) && (wdog == 4'd7) && !final_vld;
`else
  assign wdog_exp = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (cmd_fire && !cmd_illegal) state_nxt = S_WAIT;
      S_WAIT:  if (fcnt >= job_len) state_nxt = S_ISSUE;
      S_ISSUE: if (last_issue) state_nxt = final_vld ? S_GAP : S_DRAIN;
      S_DRAIN: if (final_vld || wdog_exp) state_nxt = S_GAP;
      S_GAP:   if (!res_valid || res_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      job_mode  <= 2'd0;
      job_shift <= 2'd0;
      job_len   <= '0;
      icnt      <= '0;
      vcnt      <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      err       <= 1'b0;
    end else begin
      state <= state_nxt;
      err   <= (cmd_fire && cmd_illegal) || wdog_exp;
      if (cmd_fire && !cmd_illegal) begin
        job_mode  <= cmd_mode;
        job_shift <= cmd_shift;
        job_len   <= cmd_len;
      end
      icnt <= (state == S_ISSUE) ? icnt + LEN_W'(1) : '0;
      if (!job_active)    vcnt <= '0;
      else if (dsp_valid) vcnt <= vcnt + LEN_W'(1);
      if (final_vld) begin
        res_valid <= 1'b1;
        res_data  <= dsp_out;
      end else if (res_valid && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

  // Stage 0: issue beat; cc carries the bias only on the first beat of the chain.
  always_comb begin
    aa_s  = pop ? fifo_a[rptr] : '0;
    bb_s  = pop ? fifo_b[rptr] : '0;
    cc_s  = (pop && icnt == '0) ? job_bias : '0;
    vld_s = pop;
  end

  // Stages p0..p2: delay line cleared on reset because its taps drive the DSP ports.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aa_p0 <= '0; aa_p1 <= '0; aa_p2 <= '0;
      bb_p0 <= '0; bb_p1 <= '0; bb_p2 <= '0;
      cc_p0 <= '0; cc_p1 <= '0; cc_p2 <= '0;
      vld_p0 <= 1'b0; vld_p1 <= 1'b0; vld_p2 <= 1'b0;
    end else begin
      aa_p0 <= aa_s;  aa_p1 <= aa_p0;  aa_p2 <= aa_p1;
      bb_p0 <= bb_s;  bb_p1 <= bb_p0;  bb_p2 <= bb_p1;
      cc_p0 <= cc_s;  cc_p1 <= cc_p0;  cc_p2 <= cc_p1;
      vld_p0 <= vld_s; vld_p1 <= vld_p0; vld_p2 <= vld_p1;
    end
  end

  // Tap select: the DSP consumes operands 0/1/3 cycles after start for modes 0/1/2.
  always_comb begin
    case (job_mode)
      2'd0: begin
        dsp_aa = aa_s;  dsp_bb = bb_s;  dsp_cc = cc_s;  dsp_mac = vld_s;
      end
      2'd1: begin
        dsp_aa = aa_p0; dsp_bb = bb_p0; dsp_cc = cc_p0; dsp_mac = vld_p0;
      end
      default: begin
        dsp_aa = aa_p2; dsp_bb = bb_p2; dsp_cc = cc_p2; dsp_mac = vld_p2;
      end
    endcase
  end

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Directed bench for dsp_mac_sequencer with a behavioural DSP slice (latency 0/1/3 by mode).
module tb_dsp_mac_sequencer;
  localparam int N = 9, M = 9, D = 16, LW = 5, W = N + M, NV = 9;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid, cmd_ready;
  logic [1:0]    cmd_mode, cmd_shift;
  logic [LW-1:0] cmd_len;
  logic [W-1:0]  cmd_bias;
  logic          op_valid, op_ready;
  logic [N-1:0]  op_a;
  logic [M-1:0]  op_b;
  logic          dsp_start, dsp_mac, dsp_valid;
  logic [1:0]    dsp_mode, dsp_shift;
  logic [N-1:0]  dsp_aa;
  logic [M-1:0]  dsp_bb;
  logic [W-1:0]  dsp_cc, dsp_out;
  logic          res_valid, res_ready, err;
  logic [W-1:0]  res_data;

  dsp_mac_sequencer #(.N(N), .M(M), .OPQ_DEPTH(D), .LEN_W(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode), .cmd_len(cmd_len),
    .cmd_shift(cmd_shift), .cmd_bias(cmd_bias),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .dsp_start(dsp_start), .dsp_mode(dsp_mode), .dsp_aa(dsp_aa), .dsp_bb(dsp_bb),
    .dsp_cc(dsp_cc), .dsp_mac(dsp_mac), .dsp_shift(dsp_shift),
    .dsp_out(dsp_out), .dsp_valid(dsp_valid),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .err(err)
  );

  always #5 clk = ~clk;

  // Behavioural DSP: consumes LAT cycles after start, output combinational at consumption.
  logic [3:1]          st_d;
  logic signed [W-1:0] acc, prod, base, dres;
  logic                mac_prev, consume;

  always_comb begin
    case (dsp_mode)
      2'd0:    consume = dsp_start;
      2'd1:    consume = st_d[1];
      default: consume = st_d[3];
    endcase
    prod = $signed(dsp_aa) * $signed(dsp_bb);
    base = (dsp_mac && mac_prev) ? (acc >>> dsp_shift) : $signed(dsp_cc);
    dres = base + prod;
  end
  assign dsp_valid = consume;
  assign dsp_out   = consume ? dres : '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_d <= '0; acc <= '0; mac_prev <= 1'b0;
    end else begin
      st_d     <= {st_d[2:1], dsp_start};
      mac_prev <= dsp_mac;
      if (consume) acc <= dres;
    end
  end

  int nvec = 0, nmis = 0;

  task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic push(input int a, input int b);
    op_a = a[N-1:0]; op_b = b[M-1:0]; op_valid = 1'b1;
    tick;
    op_valid = 1'b0;
  endtask

  task automatic send_cmd(input int mode, input int len, input int shift, input int bias);
    int k;
    cmd_mode = mode[1:0]; cmd_len = len[LW-1:0]; cmd_shift = shift[1:0]; cmd_bias = bias[W-1:0];
    cmd_valid = 1'b1;
    k = 0;
    while (!cmd_ready && k < 50) begin tick; k++; end
    chk("cmd_accept", cmd_ready, 1);
    tick;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_res;
    int k;
    k = 0;
    while (!res_valid && k < 100) begin tick; k++; end
    chk("res_valid_seen", res_valid, 1);
  endtask

  task automatic handshake;
    res_ready = 1'b1;
    tick;
    res_ready = 1'b0;
    chk("res_valid_clear", res_valid, 0);
    chk("cmd_ready_idle", cmd_ready, 1);
  endtask

  typedef struct packed {
    logic [1:0]    mode;
    logic [LW-1:0] len;
    logic [1:0]    shift;
    int            bias;
    int            exp;
  } vec_t;

  vec_t tv [NV];
  int   va [NV][D];
  int   vb [NV][D];

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int k, run;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_mode = '0; cmd_len = '0; cmd_shift = '0; cmd_bias = '0;
    op_valid = 1'b0; op_a = '0; op_b = '0; res_ready = 1'b0;

    tv[0] = '{mode:2'd0, len:5'd1,  shift:2'd0, bias:10,  exp:4};
    va[0][0] = 3; vb[0][0] = -2;
    tv[1] = '{mode:2'd1, len:5'd3,  shift:2'd0, bias:0,   exp:32};
    va[1][0] = 1; va[1][1] = 2; va[1][2] = 3; vb[1][0] = 4; vb[1][1] = 5; vb[1][2] = 6;
    tv[2] = '{mode:2'd0, len:5'd2,  shift:2'd1, bias:0,   exp:9};
    va[2][0] = 4; va[2][1] = 1; vb[2][0] = 4; vb[2][1] = 1;
    tv[3] = '{mode:2'd2, len:5'd2,  shift:2'd0, bias:7,   exp:14};
    va[3][0] = 2; va[3][1] = 3; vb[3][0] = 5; vb[3][1] = -1;
    tv[4] = '{mode:2'd2, len:5'd4,  shift:2'd0, bias:-5,  exp:5};
    for (int i = 0; i < 4; i++) begin va[4][i] = 1; vb[4][i] = i + 1; end
    tv[5] = '{mode:2'd1, len:5'd2,  shift:2'd2, bias:100, exp:26};
    va[5][0] = -3; va[5][1] = 2; vb[5][0] = 3; vb[5][1] = 2;
    tv[6] = '{mode:2'd2, len:5'd1,  shift:2'd3, bias:0,   exp:-20};
    va[6][0] = -4; vb[6][0] = 5;
    tv[7] = '{mode:2'd0, len:5'd16, shift:2'd0, bias:0,   exp:136};
    for (int i = 0; i < D; i++) begin va[7][i] = i + 1; vb[7][i] = 1; end
    tv[8] = '{mode:2'd2, len:5'd1,  shift:2'd0, bias:0,   exp:-65280};
    va[8][0] = 255; vb[8][0] = -256;

    // Reset state
    tick; tick;
    chk("rst_dsp_start", dsp_start, 0);
    chk("rst_dsp_mac", dsp_mac, 0);
    chk("rst_res_valid", res_valid, 0);
    rst_n = 1'b1;
    tick;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_op_ready", op_ready, 1);
    chk("rst_err", err, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_dsp_aa", dsp_aa, 0);

    // Table-driven jobs
    for (int v = 0; v < NV; v++) begin
      for (int i = 0; i < int'(tv[v].len); i++) push(va[v][i], vb[v][i]);
      if (tv[v].len == 5'd16) begin
        chk("fifo_full_op_ready", op_ready, 0);
        push(50, 50);
      end
      send_cmd(int'(tv[v].mode), int'(tv[v].len), int'(tv[v].shift), tv[v].bias);
      chk("busy_cmd_ready", cmd_ready, 0);
      k = 0;
      while (!dsp_start && k < 50) begin tick; k++; end
      run = 0;
      while (dsp_start && run < 40) begin
        if (run == 0) chk("job_dsp_mode", dsp_mode, int'(tv[v].mode));
        tick; run++;
      end
      chk("start_run_len", run, int'(tv[v].len));
      wait_res;
      chk("res_data", $signed(res_data), tv[v].exp);
      handshake;
    end

    // Mode0 len1 cycle-exact timing
    push(3, -2);
    send_cmd(0, 1, 0, 10);
    tick;
    chk("m0_start", dsp_start, 1);
    chk("m0_mac", dsp_mac, 1);
    chk("m0_aa", $signed(dsp_aa), 3);
    chk("m0_bb", $signed(dsp_bb), -2);
    chk("m0_cc", $signed(dsp_cc), 10);
    tick;
    chk("m0_res_valid_t1", res_valid, 1);
    chk("m0_res_data", $signed(res_data), 4);
    chk("m0_mac_gap", dsp_mac, 0);
    chk("m0_start_gap", dsp_start, 0);
    handshake;

    // Mode2 operand delay of 3 cycles
    push(2, 5); push(3, -1);
    send_cmd(2, 2, 0, 7);
    tick;
    chk("m2_start_t0", dsp_start, 1);
    chk("m2_mac_t0", dsp_mac, 0);
    tick; tick; tick;
    chk("m2_aa_t3", $signed(dsp_aa), 2);
    chk("m2_bb_t3", $signed(dsp_bb), 5);
    chk("m2_cc_t3", $signed(dsp_cc), 7);
    chk("m2_mac_t3", dsp_mac, 1);
    tick;
    chk("m2_aa_t4", $signed(dsp_aa), 3);
    chk("m2_bb_t4", $signed(dsp_bb), -1);
    chk("m2_cc_t4", $signed(dsp_cc), 0);
    tick;
    chk("m2_mac_t5", dsp_mac, 0);
    chk("m2_res_valid_t5", res_valid, 1);
    chk("m2_res_data", $signed(res_data), 14);
    handshake;

    // Illegal commands: err pulse, FIFO untouched, no result
    push(5, 5);
    send_cmd(3, 1, 0, 0);
    chk("ill_mode_err", err, 1);
    chk("ill_mode_cmd_ready", cmd_ready, 1);
    tick;
    chk("ill_mode_err_pulse", err, 0);
    send_cmd(0, 0, 0, 0);
    chk("ill_len0_err", err, 1);
    send_cmd(1, 17, 0, 0);
    chk("ill_len17_err", err, 1);
    tick; tick; tick;
    chk("ill_no_res", res_valid, 0);
    chk("ill_no_start", dsp_start, 0);
    send_cmd(0, 1, 0, 0);
    wait_res;
    chk("ill_fifo_kept", $signed(res_data), 25);
    handshake;

    // Result held while consumer stalls; second job blocked
    push(2, 3);
    send_cmd(1, 1, 0, 1);
    wait_res;
    push(1, 1);
    cmd_mode = 2'd0; cmd_len = 5'd1; cmd_shift = 2'd0; cmd_bias = '0; cmd_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("hold_cmd_ready", cmd_ready, 0);
      chk("hold_res_data", $signed(res_data), 7);
      chk("hold_res_valid", res_valid, 1);
    end
    res_ready = 1'b1;
    tick;
    res_ready = 1'b0;
    chk("hold_released_idle", cmd_ready, 1);
    tick;
    cmd_valid = 1'b0;
    wait_res;
    chk("second_job_res", $signed(res_data), 1);
    handshake;

    // Reset in the middle of ISSUE
    for (int i = 0; i < 4; i++) push(1, 1);
    send_cmd(2, 4, 0, 0);
    k = 0;
    while (!dsp_start && k < 50) begin tick; k++; end
    tick; tick; tick;
    chk("midrst_pre_aa", $signed(dsp_aa), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_start", dsp_start, 0);
    chk("midrst_aa", dsp_aa, 0);
    chk("midrst_mac", dsp_mac, 0);
    chk("midrst_mode", dsp_mode, 0);
    chk("midrst_res_valid", res_valid, 0);
    chk("midrst_op_ready", op_ready, 1);
    tick;
    rst_n = 1'b1;
    tick;
    send_cmd(0, 1, 0, 0);
    run = 0;
    for (int i = 0; i < 5; i++) begin
      if (dsp_start) run++;
      tick;
    end
    chk("midrst_fifo_empty", run, 0);
    chk("midrst_no_res", res_valid, 0);
    push(6, 7);
    wait_res;
    chk("midrst_recover_res", $signed(res_data), 42);
    handshake;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
